// File: rtl/alu_resp_checker.sv
// -----------------------------------------------------------------------------
// alu_resp_checker
//
// Response-side checker for an ALU under test. Each accepted transaction
// carries the operands, opcode and the DUT's result/flags. The checker
// computes the golden result, compares it with the DUT response two cycles
// after the handshake, and keeps pass/fail counters plus a record of the
// first failing transaction. One bounded batch runs per start pulse.
//
// Optional feature (compile-time macro ALU_FLAG_CHECK_EN):
//   defined   - zero/negative are always compared, overflow for ADD/SUB,
//               carry for ADDU/SUBU/SLTU.
//   undefined - flag inputs are ignored; only r is compared.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, total      batch start pulse and batch length (sampled on start)
//   in_valid/in_ready transaction handshake
//   a, b, aluc        ALU operands and opcode
//   r, zero, carry,
//   negative, overflow DUT response
//   busy              batch in progress (RUN, DRAIN, FIN)
//   done, pass        sticky completion flag and batch verdict
//   pass_cnt,fail_cnt saturating compare counters
//   err_pulse         one-cycle pulse per mismatch
//   first_fail_idx,
//   first_fail_exp    index and expected r of the first failure
// -----------------------------------------------------------------------------
module alu_resp_checker #(
  parameter int CNT_W = 16,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] total,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [OP_W-1:0]  aluc,
  input  logic [31:0]      r,
  input  logic             zero,
  input  logic             carry,
  input  logic             negative,
  input  logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_pulse,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [31:0]      first_fail_exp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Golden ALU result for the fixed opcode map.
  function automatic logic [31:0] golden_r(input logic [31:0] fa,
                                           input logic [31:0] fb,
                                           input logic [3:0]  op);
    logic [31:0] res;
    res = 32'h0000_0000;
    case (op)
      4'b0000, 4'b0010: res = fa + fb;
      4'b0001, 4'b0011: res = fa - fb;
      4'b0100:          res = fa & fb;
      4'b0101:          res = fa | fb;
      4'b0110:          res = fa ^ fb;
      4'b0111:          res = ~(fa | fb);
      4'b1000, 4'b1001: res = {fb[15:0], 16'h0000};
      4'b1010:          res = {31'h0000_0000, (fa < fb)};
      4'b1011:          res = {31'h0000_0000, ($signed(fa) < $signed(fb))};
      4'b1100:          res = $signed(fb) >>> fa[4:0];
      4'b1101:          res = fb >> fa[4:0];
      4'b1110, 4'b1111: res = fb << fa[4:0];
      default:          res = 32'h0000_0000;
    endcase
    return res;
  endfunction

`ifdef ALU_FLAG_CHECK_EN
  // Expected flags {zero,carry,negative,overflow} in [7:4] and the
  // care mask for the same bits in [3:0].
  function automatic logic [7:0] golden_flags(input logic [31:0] fa,
                                              input logic [31:0] fb,
                                              input logic [31:0] res,
                                              input logic [3:0]  op);
    logic fz, fc, fn, fv, cc, vc;
    fc = 1'b0;
    fv = 1'b0;
    cc = 1'b0;
    vc = 1'b0;
    // Set-less-than ops report operand equality on zero.
    if ((op == 4'b1010) || (op == 4'b1011)) fz = (fa == fb);
    else                                    fz = (res == 32'h0000_0000);
    if (op == 4'b1011) fn = res[0];
    else               fn = res[31];
    case (op)
      4'b0000: begin
        fc = (res < fa);  // wrapped sum is smaller than an operand on carry out
        cc = 1'b1;
      end
      4'b0001, 4'b1010: begin
        fc = (fa < fb);
        cc = 1'b1;
      end
      4'b0010: begin
        fv = (fa[31] == fb[31]) && (res[31] != fa[31]);
        vc = 1'b1;
      end
      4'b0011: begin
        fv = (fa[31] != fb[31]) && (res[31] != fa[31]);
        vc = 1'b1;
      end
      default: begin
        fc = 1'b0;
        fv = 1'b0;
      end
    endcase
    return {fz, fc, fn, fv, 1'b1, cc, 1'b1, vc};
  endfunction
`endif

  // Control registers
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_busy;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] w_acc_inc;
  logic             w_fire;
  logic             w_last_fire;
  logic             w_start_ok;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [CNT_W-1:0] r_s1_idx;
  logic [31:0]      r_s1_r;
  logic [31:0]      r_s1_exp;
  logic [3:0]       r_s1_flags;
  logic [3:0]       r_s1_fexp;
  logic [3:0]       r_s1_fcare;

  // Golden values of the incoming beat
  logic [31:0]      w_exp_r;
  logic [7:0]       w_flag_pack;
  logic             w_mismatch;

  // Stage 2 / result registers
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_ff_idx;
  logic [31:0]      r_ff_exp;
  logic             r_done;
  logic             r_pass;

  assign w_fire      = in_valid & r_in_ready;
  assign w_acc_inc   = r_acc + CNT_ONE;
  assign w_last_fire = w_fire & (w_acc_inc == r_total);
  assign w_start_ok  = start & (r_state == S_IDLE);

  // Golden result and flag expectations for the beat on the input bus.
  always_comb begin
    w_exp_r = golden_r(a, b, aluc);
`ifdef ALU_FLAG_CHECK_EN
    w_flag_pack = golden_flags(a, b, w_exp_r, aluc);
`else
    w_flag_pack = 8'h00;
`endif
  end

  // Stage-2 compare: r always, flags only where the care mask is set.
  always_comb begin
    if (r_s1_valid) begin
      w_mismatch = (r_s1_r != r_s1_exp) ||
                   (((r_s1_flags ^ r_s1_fexp) & r_s1_fcare) != 4'b0000);
    end else begin
      w_mismatch = 1'b0;
    end
  end

  // Batch FSM next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (total == CNT_ZERO) w_state_nxt = S_FIN;
          else                   w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_fire) w_state_nxt = S_DRAIN;
        else             w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        // Stage 1 empty means the last beat has been counted.
        if (r_s1_valid) w_state_nxt = S_DRAIN;
        else            w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, batch length, accept counter and the handshake ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
      r_total    <= CNT_ZERO;
      r_acc      <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_start_ok) begin
        r_total    <= total;
        r_acc      <= CNT_ZERO;
        r_in_ready <= (total != CNT_ZERO);
      end else if (w_fire) begin
        r_acc      <= w_acc_inc;
        r_in_ready <= ~w_last_fire;
      end
    end
  end

  // Stage 1: capture the accepted beat with its golden values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= CNT_ZERO;
      r_s1_r     <= 32'h0000_0000;
      r_s1_exp   <= 32'h0000_0000;
      r_s1_flags <= 4'b0000;
      r_s1_fexp  <= 4'b0000;
      r_s1_fcare <= 4'b0000;
    end else begin
      r_s1_valid <= w_fire;
      if (w_fire) begin
        r_s1_idx   <= r_acc;
        r_s1_r     <= r;
        r_s1_exp   <= w_exp_r;
        r_s1_flags <= {zero, carry, negative, overflow};
        r_s1_fexp  <= w_flag_pack[7:4];
        r_s1_fcare <= w_flag_pack[3:0];
      end
    end
  end

  // Stage 2: saturating counters, error pulse and first-failure record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt  <= CNT_ZERO;
      r_fail_cnt  <= CNT_ZERO;
      r_err_pulse <= 1'b0;
      r_ff_idx    <= CNT_ZERO;
      r_ff_exp    <= 32'h0000_0000;
    end else if (w_start_ok) begin
      r_pass_cnt  <= CNT_ZERO;
      r_fail_cnt  <= CNT_ZERO;
      r_err_pulse <= 1'b0;
      r_ff_idx    <= CNT_ZERO;
      r_ff_exp    <= 32'h0000_0000;
    end else begin
      r_err_pulse <= w_mismatch;
      if (r_s1_valid) begin
        if (w_mismatch) begin
          if (r_fail_cnt == CNT_ZERO) begin
            r_ff_idx <= r_s1_idx;
            r_ff_exp <= r_s1_exp;
          end
          if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
        end else if (r_pass_cnt != CNT_MAX) begin
          r_pass_cnt <= r_pass_cnt + CNT_ONE;
        end
      end
    end
  end

  // Sticky done/pass, set on the FIN cycle and cleared by the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_start_ok) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (r_state == S_FIN) begin
      r_done <= 1'b1;
      r_pass <= (r_fail_cnt == CNT_ZERO);
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign pass_cnt       = r_pass_cnt;
  assign fail_cnt       = r_fail_cnt;
  assign err_pulse      = r_err_pulse;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_exp = r_ff_exp;

endmodule

// File: tb/tb_alu_resp_checker.sv
// -----------------------------------------------------------------------------
// Testbench for alu_resp_checker: per-opcode vector table, hand-written
// batch sequences for the handshake/latency/reset corner cases, and random
// batches checked against a behavioural scoreboard.
// -----------------------------------------------------------------------------
module tb_alu_resp_checker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] total;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a, b, r;
  logic [3:0]       aluc;
  logic             zero, carry, negative, overflow;
  logic             busy, done, pass, err_pulse;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [31:0]      first_fail_exp;

  always #5 clk = ~clk;

  alu_resp_checker #(.CNT_W(CNT_W), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total(total),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .r(r),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
    .busy(busy), .done(done), .pass(pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_pulse(err_pulse),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp)
  );

  // fl = {zero, carry, negative, overflow}
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; logic [31:0] r; logic [3:0] fl; } txn_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; logic [31:0] exp_r; } vec_t;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;

  // scoreboard state for the current batch
  int          m_pass, m_fail, m_idx, m_err_base;
  logic [31:0] m_ff_exp;
  int          m_ff_idx;

  always @(negedge clk) if (err_pulse === 1'b1) err_seen++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    int unsigned sh;
    sh = x % 32;
    case (op)
      4'd0, 4'd2:   return x + y;
      4'd1, 4'd3:   return x - y;
      4'd4:         return x & y;
      4'd5:         return x | y;
      4'd6:         return x ^ y;
      4'd7:         return ~(x | y);
      4'd8, 4'd9:   return y * 32'd65536;
      4'd10:        return (x < y) ? 32'd1 : 32'd0;
      4'd11:        return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12:        return $signed(y) >>> sh;
      4'd13:        return y >> sh;
      default:      return y << sh;
    endcase
  endfunction

  // returns {expected zero,carry,negative,overflow, care mask for the same}
  function automatic logic [7:0] ref_flags(input txn_t t);
    logic [31:0] e;
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic fz, fc, fn, fv, cc, vc;
    e  = ref_r(t.a, t.b, t.op);
    sa = longint'($signed(t.a));
    sb = longint'($signed(t.b));
    ua = {32'd0, t.a};
    ub = {32'd0, t.b};
    fz = (t.op == 4'd10 || t.op == 4'd11) ? (t.a == t.b) : (e == 32'd0);
    fn = (t.op == 4'd11) ? e[0] : e[31];
    fc = 1'b0; cc = 1'b0; fv = 1'b0; vc = 1'b0;
    if (t.op == 4'd0) begin fc = (ua + ub) > 64'h0000_0000_FFFF_FFFF; cc = 1'b1; end
    if (t.op == 4'd1 || t.op == 4'd10) begin fc = (ua < ub); cc = 1'b1; end
    if (t.op == 4'd2) begin s = sa + sb; fv = (s > S_MAX) || (s < S_MIN); vc = 1'b1; end
    if (t.op == 4'd3) begin s = sa - sb; fv = (s > S_MAX) || (s < S_MIN); vc = 1'b1; end
    return {fz, fc, fn, fv, 1'b1, cc, 1'b1, vc};
  endfunction

  function automatic bit ref_mismatch(input txn_t t);
    bit m;
    logic [7:0] f;
    m = (t.r != ref_r(t.a, t.b, t.op));
`ifdef ALU_FLAG_CHECK_EN
    f = ref_flags(t);
    if (f[3] && t.fl[3] != f[7]) m = 1'b1;
    if (f[2] && t.fl[2] != f[6]) m = 1'b1;
    if (f[1] && t.fl[1] != f[5]) m = 1'b1;
    if (f[0] && t.fl[0] != f[4]) m = 1'b1;
`else
    f = 8'h00;
`endif
    return m;
  endfunction

  function automatic txn_t mk(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                              input logic [31:0] res, input logic [3:0] fl);
    txn_t t;
    t.a = x; t.b = y; t.op = op; t.r = res; t.fl = fl;
    return t;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input txn_t t);
    if (ref_mismatch(t)) begin
      if (m_fail == 0) begin
        m_ff_idx = m_idx;
        m_ff_exp = ref_r(t.a, t.b, t.op);
      end
      m_fail++;
    end else begin
      m_pass++;
    end
    m_idx++;
  endtask

  task automatic drive(input txn_t t);
    a = t.a; b = t.b; aluc = t.op; r = t.r;
    {zero, carry, negative, overflow} = t.fl;
  endtask

  task automatic begin_batch(input logic [CNT_W-1:0] n);
    m_pass = 0; m_fail = 0; m_idx = 0; m_ff_idx = 0; m_ff_exp = 32'd0;
    m_err_base = err_seen;
    start = 1'b1; total = n;
    tick();
    start = 1'b0; total = '0;
  endtask

  task automatic send(input txn_t t);
    int g;
    g = 0;
    drive(t);
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 50) begin tick(); g++; end
    if (in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b", in_ready);
    end else begin
      tick();
      model_accept(t);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int g;
    g = 0;
    while (done !== 1'b1 && g < bound) begin tick(); g++; end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic end_batch(input string nm);
    wait_done(nm, 30);
    chk({nm, "_pass_cnt"}, pass_cnt, m_pass);
    chk({nm, "_fail_cnt"}, fail_cnt, m_fail);
    chk({nm, "_pass"}, {31'd0, pass}, (m_fail == 0) ? 32'd1 : 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_err_pulses"}, err_seen - m_err_base, m_fail);
    if (m_fail > 0) begin
      chk({nm, "_ff_idx"}, first_fail_idx, m_ff_idx);
      chk({nm, "_ff_exp"}, first_fail_exp, m_ff_exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {27'd0, in_ready, busy, done, pass, err_pulse}, 32'd0);
    chk({nm, "_pass_cnt"}, pass_cnt, 32'd0);
    chk({nm, "_fail_cnt"}, fail_cnt, 32'd0);
    chk({nm, "_ff_idx"}, first_fail_idx, 32'd0);
    chk({nm, "_ff_exp"}, first_fail_exp, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[$];
  txn_t q4[3];
  txn_t t;
  logic [7:0] f8;
  int k, rdy, g, nb;

  initial begin
    vecs.push_back('{32'd5,         32'd7,         4'b0000, 32'd12});
    vecs.push_back('{32'd3,         32'd5,         4'b0001, 32'hFFFF_FFFE});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,         4'b0010, 32'h8000_0000});
    vecs.push_back('{32'd3,         32'd4,         4'b0011, 32'hFFFF_FFFF});
    vecs.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0100, 32'h00F0_00F0});
    vecs.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0101, 32'hFFF0_FFF0});
    vecs.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0110, 32'hFF00_FF00});
    vecs.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0111, 32'h000F_000F});
    vecs.push_back('{32'd0,         32'h1234_ABCD, 4'b1000, 32'hABCD_0000});
    vecs.push_back('{32'd9,         32'h0000_FFFF, 4'b1001, 32'hFFFF_0000});
    vecs.push_back('{32'd1,         32'hFFFF_FFFF, 4'b1010, 32'd1});
    vecs.push_back('{32'd1,         32'hFFFF_FFFF, 4'b1011, 32'd0});
    vecs.push_back('{32'd4,         32'h8000_0000, 4'b1100, 32'hF800_0000});
    vecs.push_back('{32'd4,         32'h8000_0000, 4'b1101, 32'h0800_0000});
    vecs.push_back('{32'd35,        32'd1,         4'b1110, 32'd8});
    vecs.push_back('{32'd31,        32'd1,         4'b1111, 32'h8000_0000});

    rst_n = 1'b0; start = 1'b0; total = '0; in_valid = 1'b0;
    a = '0; b = '0; aluc = '0; r = '0;
    {zero, carry, negative, overflow} = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Opcode table: r deliberately wrong so first_fail_exp exposes the golden r.
    for (int i = 0; i < vecs.size(); i++) begin
      begin_batch(16'd1);
      send(mk(vecs[i].a, vecs[i].b, vecs[i].op, ~vecs[i].exp_r, 4'b0000));
      end_batch($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_golden", i), first_fail_exp, vecs[i].exp_r);
      chk($sformatf("vec%0d_fails", i), fail_cnt, 32'd1);
    end

    // Single correct ADD.
    begin_batch(16'd1);
    send(mk(32'd3, 32'd4, 4'b0010, 32'd7, 4'b0000));
    end_batch("t1");
    chk("t1_pass_const", {31'd0, pass}, 32'd1);
    chk("t1_cnt_const", pass_cnt, 32'd1);

    // SUB with negative flag right, then wrong.
    begin_batch(16'd1);
    send(mk(32'd3, 32'd4, 4'b0011, 32'hFFFF_FFFF, 4'b0010));
    end_batch("t2a");
    chk("t2a_pass_const", {31'd0, pass}, 32'd1);
    begin_batch(16'd1);
    send(mk(32'd3, 32'd4, 4'b0011, 32'hFFFF_FFFF, 4'b0000));
    end_batch("t2b");
`ifdef ALU_FLAG_CHECK_EN
    chk("t2b_fail_const", fail_cnt, 32'd1);
    chk("t2b_pulse_const", err_seen - m_err_base, 32'd1);
`else
    chk("t2b_fail_const", fail_cnt, 32'd0);
`endif

    // Four beats, last one ADD overflow reported wrongly.
    begin_batch(16'd4);
    send(mk(32'd1, 32'd2, 4'b0000, 32'd3, 4'b0000));
    send(mk(32'hFF, 32'h0F, 4'b0100, 32'h0F, 4'b0000));
    send(mk(32'd5, 32'd5, 4'b0110, 32'd0, 4'b1000));
    send(mk(32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 4'b0010));
    end_batch("t3");
`ifdef ALU_FLAG_CHECK_EN
    chk("t3_fail_const", fail_cnt, 32'd1);
    chk("t3_idx_const", first_fail_idx, 32'd3);
    chk("t3_exp_const", first_fail_exp, 32'h8000_0000);
`else
    chk("t3_fail_const", fail_cnt, 32'd0);
`endif

    // in_valid held high: ready exactly 3 cycles, 2-cycle counter latency.
    q4[0] = mk(32'd10, 32'd20, 4'b0000, 32'd30, 4'b0000);
    q4[1] = mk(32'd1, 32'd2, 4'b0101, 32'd3, 4'b0000);
    q4[2] = mk(32'd4, 32'd1, 4'b1110, 32'd16, 4'b0000);
    begin_batch(16'd3);
    k = 0; rdy = 0; g = 0;
    in_valid = 1'b1;
    while (k < 3 && g < 20) begin
      drive(q4[k]);
      if (in_ready === 1'b1) begin rdy++; model_accept(q4[k]); k++; end
      tick();
      g++;
    end
    chk("t4_all_accepted", k, 32'd3);
    chk("t4_cnt_lat1", pass_cnt, 32'd2);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) chk("t4_cnt_lat2", pass_cnt, 32'd3);
      if (in_ready === 1'b1) rdy++;
      tick();
    end
    in_valid = 1'b0;
    chk("t4_ready_cycles", rdy, 32'd3);
    end_batch("t4");

    // Empty batch.
    begin_batch(16'd0);
    chk("t5_busy_fin", {31'd0, busy}, 32'd1);
    g = 0;
    while (done !== 1'b1 && g < 2) begin tick(); g++; end
    chk("t5_done_2cyc", {31'd0, done}, 32'd1);
    chk("t5_pass", {31'd0, pass}, 32'd1);
    chk("t5_counts", {pass_cnt, fail_cnt}, 32'd0);

    // start while busy is ignored.
    begin_batch(16'd2);
    send(mk(32'd1, 32'd1, 4'b0000, 32'd2, 4'b0000));
    start = 1'b1; total = 16'd5;
    tick();
    start = 1'b0; total = '0;
    send(mk(32'd1, 32'd1, 4'b0000, 32'd2, 4'b0000));
    end_batch("t5b");
    chk("t5b_cnt_const", pass_cnt, 32'd2);

    // Reset mid-batch, then a clean batch.
    begin_batch(16'd5);
    send(mk(32'd2, 32'd2, 4'b0000, 32'd4, 4'b0000));
    send(mk(32'd2, 32'd3, 4'b0000, 32'd4, 4'b0000));
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    tick();
    tick();
    chk_zero("t6_rst_hold");
    rst_n = 1'b1;
    tick();
    begin_batch(16'd2);
    send(mk(32'd6, 32'd7, 4'b0000, 32'd13, 4'b0000));
    send(mk(32'd8, 32'd1, 4'b0001, 32'd7, 4'b0000));
    end_batch("t6_clean");
    chk("t6_cnt_const", pass_cnt, 32'd2);

    // Random batches against the scoreboard.
    for (int bt = 0; bt < 3; bt++) begin
      nb = 10 + bt * 10;
      begin_batch(16'(nb));
      for (int i = 0; i < nb; i++) begin
        t.a  = $urandom;
        t.b  = ($urandom_range(0, 7) == 0) ? t.a : $urandom;
        t.op = 4'($urandom_range(0, 15));
        t.r  = ref_r(t.a, t.b, t.op);
        f8   = ref_flags(t);
        t.fl = f8[7:4];
        if ($urandom_range(0, 4) == 0) t.fl = t.fl ^ 4'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) t.r = t.r ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) tick();
        send(t);
      end
      end_batch($sformatf("rand%0d", bt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
